// File: rtl/multi_cycle_control.sv
// multi_cycle_control: main control FSM for a multi-cycle MIPS-style datapath.
// FETCH, MEMRD and MEMWR stall on MemReady. A bounded wait counter forces a
// sticky Timeout and a move to HALT when memory never answers.
// Optional build macro: ILLEGAL_TRAP_EN. When it is defined, an undecoded
// opcode in DECODE sets a sticky Illegal flag and traps to HALT. When it is
// undefined, an undecoded opcode is a NOP and Illegal is tied low.
`timescale 1ns/1ps

module multi_cycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       SignExtend,
    output logic       Halted,
    output logic       Illegal,
    output logic       Timeout,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_ICOMP  = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // The counter must be able to hold WAIT_LIMIT itself.
    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   wait_cnt;
    logic [5:0]      op_q;
    logic            timeout_q;
    logic            in_wait;
    logic            wait_expired;

    // Memory-wait states, and the cycle in which the wait budget runs out.
    assign in_wait      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign wait_expired = in_wait && !MemReady && (wait_cnt == CW'(WAIT_LIMIT));

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values and simulation matches the synthesized flops.
        if (Reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Wait counter, captured opcode and sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wait_cnt  <= '0;
            op_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (in_wait && !MemReady) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (state == S_DECODE) begin
                op_q <= Opcode;
            end
            if (wait_expired) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal-opcode flag: DECODE only reaches HALT on an undecoded opcode.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            illegal_q <= 1'b0;
        end else if ((state == S_DECODE) && (next_state == S_HALT)) begin
            illegal_q <= 1'b1;
        end
    end

    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        // NOTE: every combinational output is given a default before the case so
        // no path leaves it unassigned and no latch is inferred.
        next_state = state;
        case (state)
            S_FETCH: begin
                if (MemReady)          next_state = S_DECODE;
                else if (wait_expired) next_state = S_HALT;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:                          next_state = S_EXEC;
                    OP_LW, OP_SW:                      next_state = S_MEMADR;
                    OP_BEQ:                            next_state = S_BRANCH;
                    OP_J:                              next_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_IEXEC;
`ifdef ILLEGAL_TRAP_EN
                    default:                           next_state = S_HALT;
`else
                    default:                           next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: next_state = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (MemReady)          next_state = S_MEMWB;
                else if (wait_expired) next_state = S_HALT;
            end
            S_MEMWR: begin
                if (MemReady)          next_state = S_FETCH;
                else if (wait_expired) next_state = S_HALT;
            end
            S_EXEC:   next_state = S_RCOMP;
            S_IEXEC:  next_state = S_ICOMP;
            S_MEMWB, S_RCOMP, S_ICOMP, S_BRANCH, S_JUMP: next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_HALT;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        SignExtend  = 1'b0;
        Halted      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 4'b0000;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 4'b0010;
                PCWrite = MemReady;
                IRWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUOp      = 4'b0010;
                SignExtend = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 4'b0010;
                SignExtend = 1'b1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 4'b1111;
            end
            S_RCOMP: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 4'b0110;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_IEXEC, S_ICOMP: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                RegWrite = (state == S_ICOMP);
                // Immediate ALU function comes from the opcode latched in DECODE.
                case (op_q)
                    OP_ADDI: begin ALUOp = 4'b0010; SignExtend = 1'b1; end
                    OP_ANDI: begin ALUOp = 4'b0000; SignExtend = 1'b0; end
                    OP_ORI:  begin ALUOp = 4'b0001; SignExtend = 1'b0; end
                    OP_SLTI: begin ALUOp = 4'b0111; SignExtend = 1'b1; end
                    default: begin ALUOp = 4'b0000; SignExtend = 1'b0; end
                endcase
            end
            S_HALT:  Halted = 1'b1;
            default: Halted = 1'b0;
        endcase
    end

    assign Timeout = timeout_q;
    assign State   = state;

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, meaning the maximum number of consecutive cycles spent waiting on MemReady in one memory state.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Opcode, input, 6 bits: instruction register bits [31:26].
REQ-005 SHALL have port MemReady, input, 1 bit: memory access completes in this cycle.
REQ-006 SHALL have these 1-bit outputs: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst, SignExtend, Halted, Illegal, Timeout.
REQ-007 SHALL have these multi-bit outputs: PCSource (2 bits), ALUSrcB (2 bits), ALUOp (4 bits), State (4 bits, the current state code).

Function
REQ-008 SHALL use these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9, IEXEC=10, ICOMP=11, HALT=12; codes 13-15 SHALL go to HALT.
REQ-009 SHALL decode these opcodes in DECODE: R-type 000000 to EXEC; LW 100011 and SW 101011 to MEMADR; BEQ 000100 to BRANCH; J 000010 to JUMP; ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010 to IEXEC.
REQ-010 SHALL take these transitions: MEMADR goes to MEMRD for LW and to MEMWR for SW; MEMRD goes to MEMWB; EXEC goes to RCOMP; IEXEC goes to ICOMP; MEMWB, MEMWR, RCOMP, ICOMP, BRANCH and JUMP go to FETCH.
REQ-011 SHALL hold FETCH, MEMRD and MEMWR while MemReady=0, and advance only in a cycle with MemReady=1.
REQ-012 In FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0010, PCSource=00; PCWrite and IRWrite SHALL be 1 only when MemReady=1.
REQ-013 In DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=0010, SignExtend=1 (branch target).
REQ-014 In MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=0010, SignExtend=1.
REQ-015 In MEMRD SHALL drive MemRead=1 and IorD=1; in MEMWR SHALL drive MemWrite=1 and IorD=1; in MEMWB SHALL drive RegWrite=1, MemToReg=1, RegDst=0.
REQ-016 In EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=1111; in RCOMP SHALL drive RegWrite=1, RegDst=1, MemToReg=0.
REQ-017 In BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=0110, PCWriteCond=1, PCSource=01; in JUMP SHALL drive PCWrite=1, PCSource=10.
REQ-018 In IEXEC and ICOMP SHALL drive ALUSrcA=1 and ALUSrcB=10, with ALUOp ADDI=0010, ANDI=0000, ORI=0001, SLTI=0111 and SignExtend=1 for ADDI/SLTI and 0 for ANDI/ORI; ICOMP SHALL additionally drive RegWrite=1, RegDst=0, MemToReg=0.
REQ-019 In IEXEC and ICOMP SHALL take the ALUOp/SignExtend opcode from a register captured in DECODE, not from live Opcode.
REQ-020 Every output not named for a state SHALL be 0 in that state.
REQ-021 SHALL use a wait counter that clears on every state change and increments each cycle spent in FETCH, MEMRD or MEMWR with MemReady=0.
REQ-022 When the counter equals WAIT_LIMIT with MemReady still 0, SHALL set Timeout=1 (sticky) and go to HALT next cycle; MemReady=1 in that same cycle SHALL take priority and proceed normally.
REQ-023 In HALT SHALL drive Halted=1 with all strobes 0 and remain there until Reset.

Reset
REQ-024 With Reset=1 at a rising edge, SHALL enter FETCH and clear the wait counter, the captured opcode, Timeout and Illegal, regardless of current state, including mid-wait.
REQ-025 After reset all outputs SHALL equal their FETCH values; Halted, Illegal and Timeout SHALL be 0.

Configuration
REQ-026 With ILLEGAL_TRAP_EN defined, an undecoded opcode in DECODE SHALL set Illegal=1 (sticky) and go to HALT.
REQ-027 Without ILLEGAL_TRAP_EN, an undecoded opcode SHALL return to FETCH (NOP), Illegal SHALL be tied to 0, and the only ways into HALT SHALL be timeout and state codes 13-15.

Verification
REQ-028 LW 100011 with MemReady=1 always -> State 0,1,2,3,4,0 over 5 cycles; MEMWB has RegWrite=1 and MemToReg=1.
REQ-029 SW with MemReady=0 for 3 cycles in MEMWR, then 1 -> MemWrite=1 for 4 cycles, then FETCH; Timeout=0.
REQ-030 ORI 001101 with Opcode changed to 000000 after DECODE -> IEXEC/ICOMP keep ALUOp=0001 and SignExtend=0; ICOMP has RegWrite=1.
REQ-031 WAIT_LIMIT=15, MemReady=0 in FETCH for 16 cycles -> Timeout=1 and Halted=1; a later Reset returns to FETCH with Timeout=0.
REQ-032 Opcode 111111 -> with ILLEGAL_TRAP_EN: Illegal=1 and State=12; without it: State=0 after DECODE and Illegal=0.
REQ-033 Reset asserted during MEMRD wait -> next State=0, PCWrite=0, and the wait counter restarts at 0.
